// File: rtl/mux_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_ctrl_if
// Description : Select, readback and snapshot signals between the scanner,
//               its 4:1 mux and the snapshot consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_scan_ctrl_if;
  logic       start;
  logic       cont;
  logic [1:0] S;
  logic       Y_in;
  logic       busy;
  logic       scan_done;
  logic [3:0] dout;
  logic       dout_valid;
  logic       dout_ready;

  modport master (
    input  start, cont, Y_in, dout_ready,
    output S, busy, scan_done, dout, dout_valid
  );

  modport slave (
    output start, cont, Y_in, dout_ready,
    input  S, busy, scan_done, dout, dout_valid
  );
endinterface
`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_ctrl
// Description : Steps a 4:1 mux select through channels 0..3, samples the mux
//               output after a settle time and delivers a 4-bit snapshot on a
//               valid/ready port. Optional macro MUX_SCAN_CHG_EN suppresses
//               delivery of a snapshot equal to the last delivered one.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_ctrl #(
  parameter int SETTLE_CYC = 1
) (
  input  logic           clk,
  input  logic           rst,
  mux_scan_ctrl_if.master bus
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_settle = 2'd1;
  localparam logic [1:0] c_st_sample = 2'd2;
  localparam logic [1:0] c_st_out    = 2'd3;

  // Counter counts down to zero, so SETTLE lasts exactly SETTLE_CYC cycles.
  localparam logic [3:0] c_settle_load = 4'(SETTLE_CYC - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] s_q, s_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] shadow_q, shadow_d;
  logic [3:0] dout_q, dout_d;
  logic       dout_valid_q, dout_valid_d;
  logic       scan_done_q, scan_done_d;
  logic       busy_q, busy_d;

  logic [3:0] w_snapshot;
  logic       w_handshake;
  logic       w_skip;

  assign w_snapshot  = {bus.Y_in, shadow_q};
  assign w_handshake = dout_valid_q & bus.dout_ready;

`ifdef MUX_SCAN_CHG_EN
  logic [3:0] last_q, last_d;

  assign w_skip = (w_snapshot == last_q);

  always_comb begin
    last_d = last_q;
    if (state_q == c_st_out && w_handshake) begin
      last_d = dout_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 4'b0000;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign w_skip = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    scan_done_d  = 1'b0;

    case (state_q)
      c_st_idle: begin
        s_d = 2'd0;
        if (bus.start) begin
          state_d = c_st_settle;
          cnt_d   = c_settle_load;
        end
      end

      c_st_settle: begin
        if (cnt_q == 4'd0) begin
          state_d = c_st_sample;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      c_st_sample: begin
        case (s_q)
          2'd0:    shadow_d[0] = bus.Y_in;
          2'd1:    shadow_d[1] = bus.Y_in;
          2'd2:    shadow_d[2] = bus.Y_in;
          default: shadow_d    = shadow_q;
        endcase

        if (s_q != 2'd3) begin
          s_d     = s_q + 2'd1;
          cnt_d   = c_settle_load;
          state_d = c_st_settle;
        end else begin
          scan_done_d = 1'b1;
          if (w_skip) begin
            // Unchanged snapshot: restart or idle directly, nothing delivered.
            s_d     = 2'd0;
            cnt_d   = c_settle_load;
            state_d = bus.cont ? c_st_settle : c_st_idle;
          end else begin
            dout_d       = w_snapshot;
            dout_valid_d = 1'b1;
            state_d      = c_st_out;
          end
        end
      end

      c_st_out: begin
        if (w_handshake) begin
          dout_valid_d = 1'b0;
          s_d          = 2'd0;
          cnt_d        = c_settle_load;
          state_d      = bus.cont ? c_st_settle : c_st_idle;
        end
      end

      default: begin
        state_d = c_st_idle;
        s_d     = 2'd0;
      end
    endcase

    busy_d = (state_d != c_st_idle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= c_st_idle;
      s_q          <= 2'd0;
      cnt_q        <= 4'd0;
      shadow_q     <= 3'b000;
      dout_q       <= 4'b0000;
      dout_valid_q <= 1'b0;
      scan_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      scan_done_q  <= scan_done_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.S          = s_q;
  assign bus.busy       = busy_q;
  assign bus.scan_done  = scan_done_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_ctrl
// Description : Self-checking bench for mux_scan_ctrl (SETTLE_CYC=1) with a
//               behavioural 4:1 mux and a snapshot scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] mux_i;
  logic [3:0] exp_q[$];
  int         n_checks;
  int         n_fail;

  mux_scan_ctrl_if bus ();

  mux_scan_ctrl #(.SETTLE_CYC(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.Y_in = mux_i[bus.S];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (bus.S !== 2'd0 || bus.busy !== 1'b0 || bus.dout_valid !== 1'b0 ||
        bus.dout !== 4'b0000 || bus.scan_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init: S=%0d busy=%b valid=%b dout=%b done=%b, required 0/0/0/0000/0",
               bus.S, bus.busy, bus.dout_valid, bus.dout, bus.scan_done);
    end
    // Mid-operation reset held for two cycles
    mux_i = 4'b1111; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (bus.S !== 2'd0 || bus.busy !== 1'b0 || bus.dout_valid !== 1'b0 ||
        bus.dout !== 4'b0000 || bus.scan_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_op: S=%0d busy=%b valid=%b dout=%b done=%b, required 0/0/0/0000/0",
               bus.S, bus.busy, bus.dout_valid, bus.dout, bus.scan_done);
    end
  endtask

  task automatic test_single();
    logic [3:0] exp;
    @(negedge clk);
    mux_i = 4'b1010; bus.dout_ready = 1'b1; bus.cont = 1'b0; bus.start = 1'b1;
    exp_q.push_back(4'b1010);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      n_checks++;
      if (bus.S !== 2'(i / 2) || bus.dout_valid !== 1'b0 || bus.busy !== 1'b1 ||
          bus.scan_done !== 1'b0) begin
        n_fail++;
        $display("FAIL single_seq cycle %0d: S=%0d valid=%b busy=%b done=%b, required S=%0d valid=0 busy=1 done=0",
                 i, bus.S, bus.dout_valid, bus.busy, bus.scan_done, i / 2);
      end
    end
    @(negedge clk);
    exp = exp_q.pop_front();
    n_checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== exp || bus.scan_done !== 1'b1 || bus.S !== 2'd3) begin
      n_fail++;
      $display("FAIL single_out: valid=%b dout=%b done=%b S=%0d, required valid=1 dout=%b done=1 S=3",
               bus.dout_valid, bus.dout, bus.scan_done, bus.S, exp);
    end
    @(negedge clk);
    n_checks++;
    if (bus.dout_valid !== 1'b0 || bus.busy !== 1'b0 || bus.S !== 2'd0 || bus.scan_done !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after: valid=%b busy=%b S=%0d done=%b, required 0/0/0/0",
               bus.dout_valid, bus.busy, bus.S, bus.scan_done);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp;
    @(negedge clk);
    mux_i = 4'b1010; bus.dout_ready = 1'b0; bus.cont = 1'b0; bus.start = 1'b1;
    exp_q.push_back(4'b1010);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    exp = exp_q.pop_front();
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      // Input changes while stalled must not disturb the held snapshot
      mux_i = 4'(j);
      n_checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== exp || bus.S !== 2'd3 || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: valid=%b dout=%b S=%0d busy=%b, required 1/%b/3/1",
                 j, bus.dout_valid, bus.dout, bus.S, bus.busy, exp);
      end
    end
    bus.dout_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.dout_valid !== 1'b0 || bus.busy !== 1'b0 || bus.S !== 2'd0) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b busy=%b S=%0d, required 0/0/0",
               bus.dout_valid, bus.busy, bus.S);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    int         n_del;
    int         last_del;
    @(negedge clk);
    mux_i = 4'b1010; bus.dout_ready = 1'b1; bus.cont = 1'b1; bus.start = 1'b1;
    exp_q.push_back(4'b1010);
    exp_q.push_back(4'b0101);
    n_del = 0; last_del = -1;
    for (int cyc = 0; cyc < 40 && n_del < 2; cyc++) begin
      @(negedge clk);
      bus.start = (cyc == 3) || (cyc == 12);
      n_checks++;
      if (bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_busy cycle %0d: busy=%b, required 1", cyc, bus.busy);
      end
      if (bus.dout_valid === 1'b1) begin
        exp = exp_q.pop_front();
        n_checks++;
        if (bus.dout !== exp || cyc !== ((n_del == 0) ? 8 : last_del + 9)) begin
          n_fail++;
          $display("FAIL b2b_snapshot %0d: dout=%b at cycle %0d, required %b at cycle %0d",
                   n_del, bus.dout, cyc, exp, (n_del == 0) ? 8 : last_del + 9);
        end
        last_del = cyc;
        n_del++;
        if (n_del == 1) mux_i = 4'b0101;
        else bus.cont = 1'b0;
      end
    end
    bus.start = 1'b0;
    n_checks++;
    if (n_del != 2) begin
      n_fail++;
      $display("FAIL b2b_count: %0d snapshots delivered, required 2", n_del);
    end
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: busy=%b valid=%b, required 0/0", bus.busy, bus.dout_valid);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic found;
    logic seen_valid;
    @(negedge clk);
    mux_i = 4'b1100; bus.dout_ready = 1'b1; bus.cont = 1'b0; bus.start = 1'b1;
    found = 1'b0;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.S === 2'd2) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL rmid_reach: S=%0d, required S=2 within 20 cycles", bus.S);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (bus.S !== 2'd0 || bus.busy !== 1'b0 || bus.dout_valid !== 1'b0 || bus.scan_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_state: S=%0d busy=%b valid=%b done=%b, required 0/0/0/0",
               bus.S, bus.busy, bus.dout_valid, bus.scan_done);
    end
    seen_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.dout_valid !== 1'b0 || bus.busy !== 1'b0) seen_valid = 1'b1;
    end
    n_checks++;
    if (seen_valid) begin
      n_fail++;
      $display("FAIL rmid_quiet: activity after reset=1, required 0");
    end
  endtask

`ifdef MUX_SCAN_CHG_EN
  task automatic test_change_detect();
    logic [3:0] exp;
    int         n_del;
    int         n_skip;
    @(negedge clk);
    mux_i = 4'b0110; bus.dout_ready = 1'b1; bus.cont = 1'b1; bus.start = 1'b1;
    exp_q.push_back(4'b0110);
    exp_q.push_back(4'b0111);
    n_del = 0; n_skip = 0;
    for (int cyc = 0; cyc < 80 && n_del < 2; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.scan_done === 1'b1) begin
        if (bus.dout_valid === 1'b1) begin
          exp = exp_q.pop_front();
          n_checks++;
          if (bus.dout !== exp || n_skip !== ((n_del == 0) ? 0 : 2)) begin
            n_fail++;
            $display("FAIL chg_deliver %0d: dout=%b after %0d skips, required %b after %0d skips",
                     n_del, bus.dout, n_skip, exp, (n_del == 0) ? 0 : 2);
          end
          n_del++;
          if (n_del == 2) bus.cont = 1'b0;
        end else begin
          n_skip++;
          n_checks++;
          if (bus.dout !== 4'b0110) begin
            n_fail++;
            $display("FAIL chg_skip %0d: dout=%b, required 0110 held", n_skip, bus.dout);
          end
          if (n_skip == 2) mux_i = 4'b0111;
        end
      end
    end
    n_checks++;
    if (n_del != 2 || n_skip != 2) begin
      n_fail++;
      $display("FAIL chg_count: deliveries=%0d skips=%0d, required 2 and 2", n_del, n_skip);
    end
    repeat (2) @(negedge clk);
  endtask
`else
  task automatic test_repeat_deliver();
    logic [3:0] exp;
    int         n_del;
    @(negedge clk);
    mux_i = 4'b0110; bus.dout_ready = 1'b1; bus.cont = 1'b1; bus.start = 1'b1;
    exp_q.push_back(4'b0110);
    exp_q.push_back(4'b0110);
    n_del = 0;
    for (int cyc = 0; cyc < 40 && n_del < 2; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.dout_valid === 1'b1) begin
        exp = exp_q.pop_front();
        n_checks++;
        if (bus.dout !== exp || bus.scan_done !== 1'b1) begin
          n_fail++;
          $display("FAIL repeat_deliver %0d: dout=%b done=%b, required %b done=1",
                   n_del, bus.dout, bus.scan_done, exp);
        end
        n_del++;
        if (n_del == 2) bus.cont = 1'b0;
      end
    end
    n_checks++;
    if (n_del != 2) begin
      n_fail++;
      $display("FAIL repeat_count: %0d deliveries, required 2", n_del);
    end
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; mux_i = 4'b0000;
    bus.start = 1'b0; bus.cont = 1'b0; bus.dout_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_scan();
`ifdef MUX_SCAN_CHG_EN
    test_change_detect();
`else
    test_repeat_deliver();
`endif
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
